// File: rtl/load_store_ctrl_pkg.sv
// Shared encodings for the load/store controller: access widths, FSM states
// and the request legality rule used when a request is accepted.
package load_store_ctrl_pkg;

    // func3 access width encodings, shared with the decoder's mem_access_width
    localparam logic [2:0] WidthB  = 3'b000;
    localparam logic [2:0] WidthH  = 3'b001;
    localparam logic [2:0] WidthW  = 3'b010;
    localparam logic [2:0] WidthBu = 3'b100;
    localparam logic [2:0] WidthHu = 3'b101;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } lsu_state_e;

    // A request is legal when the width is defined and the address is naturally aligned
    function automatic logic lsu_req_legal(input logic [2:0] width, input logic [1:0] offset);
        logic legal;
        case (width)
            WidthB, WidthBu: legal = 1'b1;
            WidthH, WidthHu: legal = ~offset[0];
            WidthW:          legal = (offset == 2'b00);
            default:         legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable and store-data replication for an
// outgoing request, plus lane extraction and sign/zero extension of load data.
module lsu_align
    import load_store_ctrl_pkg::*;
(
    input  logic [2:0]  req_width,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  ld_width,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_bus_rdata,
    output logic [3:0]  req_sel,
    output logic [31:0] req_wdata_rep,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    // Byte enables and replicated store data for the request being accepted
    always_comb begin
        req_sel       = 4'b0000;
        req_wdata_rep = req_wdata;
        case (req_width)
            WidthB, WidthBu: begin
                req_sel       = 4'b0001 << req_off;
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            WidthH, WidthHu: begin
                req_sel       = req_off[1] ? 4'b1100 : 4'b0011;
                req_wdata_rep = {2{req_wdata[15:0]}};
            end
            WidthW: begin
                req_sel       = 4'b1111;
                req_wdata_rep = req_wdata;
            end
            default: begin
                req_sel       = 4'b0000;
                req_wdata_rep = req_wdata;
            end
        endcase
    end

    // Move the addressed lane down to bit 0 and extend it to 32 bits
    always_comb begin
        ld_shifted = ld_bus_rdata >> {ld_off, 3'b000};
        case (ld_width)
            WidthB:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            WidthBu: ld_data = {24'h000000, ld_shifted[7:0]};
            WidthH:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            WidthHu: ld_data = {16'h0000, ld_shifted[15:0]};
            default: ld_data = ld_bus_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_ctrl.sv
// Load/store controller: accepts one decoded memory access at a time, runs a
// single classic bus cycle with timeout, and returns aligned load data.
module load_store_ctrl
    import load_store_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_width_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i
);

    lsu_state_e  state_q;
    logic [7:0]  cnt_q;
    logic        cyc_q;
    logic        we_q;
    logic        done_q;
    logic        err_q;
    logic [2:0]  width_q;
    logic [31:0] addr_q;
    logic [3:0]  sel_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic [3:0]  req_sel;
    logic [31:0] req_wdata_rep;
    logic [31:0] ld_data;

    lsu_align u_align (
        .req_width     (req_width_i),
        .req_off       (req_addr_i[1:0]),
        .req_wdata     (req_wdata_i),
        .ld_width      (width_q),
        .ld_off        (addr_q[1:0]),
        .ld_bus_rdata  (bus_rdata_i),
        .req_sel       (req_sel),
        .req_wdata_rep (req_wdata_rep),
        .ld_data       (ld_data)
    );

    // Access FSM with timeout counter; all bus and result outputs are registered here
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            width_q <= 3'b000;
            addr_q  <= 32'h0;
            sel_q   <= 4'b0000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        if (lsu_req_legal(req_width_i, req_addr_i[1:0])) begin
                            addr_q  <= req_addr_i;
                            sel_q   <= req_sel;
                            wdata_q <= req_wdata_rep;
                            we_q    <= req_we_i;
                            width_q <= req_width_i;
                            cyc_q   <= 1'b1;
                            cnt_q   <= 8'd0;
                            state_q <= StAccess;
                        end else begin
                            // Rejected without touching the bus
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            rdata_q <= 32'h0;
                            state_q <= StDone;
                        end
                    end
                end
                StAccess: begin
                    if (bus_ack_i || bus_err_i) begin
                        // ack together with err counts as an error
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= bus_err_i;
                        rdata_q <= (!we_q && !bus_err_i) ? ld_data : 32'h0;
                        state_q <= StDone;
                    end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StDone: begin
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stall releases in DONE so the core can retire the access
    always_comb begin
        stall_o = req_valid_i && (state_q != StDone);
    end

    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign bus_cyc_o   = cyc_q;
    assign bus_stb_o   = cyc_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = {addr_q[31:2], 2'b00};
    assign bus_sel_o   = sel_q;
    assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Self-checking bench for load_store_ctrl: directed scenarios plus randomized
// accesses checked against a byte-lane reference model.
module tb_load_store_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_width;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        bus_cyc, bus_stb, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;
    logic        bus_ack, bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          done_cycle;
        int          cyc_cycles;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        unstable;
        logic        stall_bad;
        logic        stall_at_done;
        logic        done_after;
    } obs_t;

    load_store_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_we_i    (req_we),
        .req_width_i (req_width),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .stall_o     (stall),
        .done_o      (done),
        .err_o       (err),
        .rdata_o     (rdata),
        .bus_cyc_o   (bus_cyc),
        .bus_stb_o   (bus_stb),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_sel_o   (bus_sel),
        .bus_wdata_o (bus_wdata),
        .bus_ack_i   (bus_ack),
        .bus_err_i   (bus_err),
        .bus_rdata_i (bus_rdata)
    );

    always #5 clk = ~clk;

    // Reference: lanes covered by the access, per-lane store byte, extracted load value
    function automatic void model(input logic [2:0] w, input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] srd, output bit legal,
                                  output logic [3:0] sel, output logic [31:0] wd,
                                  output logic [31:0] rd);
        int size, off;
        bit sgn;
        logic [31:0] mask;
        size = 0; sgn = 0;
        case (w)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: begin size = 4; sgn = 0; end
            3'd4: begin size = 1; sgn = 0; end
            3'd5: begin size = 2; sgn = 0; end
            default: size = 0;
        endcase
        off = int'(a % 4);
        sel = 4'b0000; wd = 32'h0; rd = 32'h0; legal = 0;
        if (size != 0) begin
            legal = ((a % size) == 0);
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) sel[i] = 1'b1;
                wd = wd | (((d >> (8 * (i % size))) & 32'hff) << (8 * i));
            end
            mask = (size == 4) ? 32'hffff_ffff : ((32'h1 << (8 * size)) - 32'h1);
            rd = (srd >> (8 * off)) & mask;
            if (sgn && size < 4 && rd[8 * size - 1]) rd = rd | ~mask;
        end
    endfunction

    // Drives one request and records what the DUT does; lat<0 = slave never answers,
    // mode 0 ack / 1 err / 2 ack+err, drop releases req_valid once the bus cycle runs
    task automatic do_access(input logic we, input logic [2:0] w, input logic [31:0] a,
                             input logic [31:0] d, input int lat, input int mode,
                             input logic [31:0] srd, input bit drop, output obs_t o);
        o.done_cycle = -1; o.cyc_cycles = 0; o.err = 0; o.rdata = 0; o.sel = 0;
        o.addr = 0; o.wdata = 0; o.we = 0; o.unstable = 0; o.stall_bad = 0;
        o.stall_at_done = 0; o.done_after = 0;
        @(negedge clk);
        req_valid = 1; req_we = we; req_width = w; req_addr = a; req_wdata = d;
        bus_ack = 0; bus_err = 0; bus_rdata = srd;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus_ack = 0; bus_err = 0;
            if (done) begin
                o.done_cycle = c; o.err = err; o.rdata = rdata; o.stall_at_done = stall;
                break;
            end
            if (!drop && !stall) o.stall_bad = 1;
            if (bus_cyc) begin
                if (o.cyc_cycles == 0) begin
                    o.sel = bus_sel; o.addr = bus_addr; o.wdata = bus_wdata; o.we = bus_we;
                end else if (o.sel !== bus_sel || o.addr !== bus_addr ||
                             o.wdata !== bus_wdata || o.we !== bus_we || !bus_stb) begin
                    o.unstable = 1;
                end
                o.cyc_cycles++;
                if (drop) req_valid = 0;
                if (lat >= 0 && o.cyc_cycles - 1 == lat) begin
                    bus_ack = (mode != 1); bus_err = (mode != 0);
                end
            end
        end
        req_valid = 0;
        @(negedge clk);
        o.done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 0; req_valid = 0; req_we = 0; req_width = 0; req_addr = 0; req_wdata = 0;
        bus_ack = 0; bus_err = 0; bus_rdata = 32'hffff_ffff;
        #1;
        n_checks++;
        if ({bus_cyc, bus_stb, bus_we, done, err, stall} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 000000",
                               {bus_cyc, bus_stb, bus_we, done, err, stall});
        end
        n_checks++;
        if ({bus_addr, bus_sel, bus_wdata, rdata} !== 100'h0) begin
            n_fail++; $display("FAIL reset_data got %h %h %h %h want 0", bus_addr, bus_sel,
                               bus_wdata, rdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_store_word();
        obs_t o;
        do_access(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 0, o);
        n_checks++;
        if (o.sel !== 4'b1111 || o.addr !== 32'h100 || o.wdata !== 32'hDEADBEEF || o.we !== 1) begin
            n_fail++; $display("FAIL sw_bus got sel %b addr %h wdata %h we %b want 1111 100 deadbeef 1",
                               o.sel, o.addr, o.wdata, o.we);
        end
        n_checks++;
        if (o.done_cycle != 2 || o.err !== 0 || o.rdata !== 0) begin
            n_fail++; $display("FAIL sw_done got cycle %0d err %b rdata %h want 2 0 0",
                               o.done_cycle, o.err, o.rdata);
        end
        n_checks++;
        if (o.stall_bad || o.stall_at_done || o.done_after) begin
            n_fail++; $display("FAIL sw_handshake got stall_bad %b stall_done %b done_after %b want 0 0 0",
                               o.stall_bad, o.stall_at_done, o.done_after);
        end
    endtask

    task automatic test_store_byte();
        obs_t o;
        do_access(1, 3'b000, 32'h103, 32'h0000_00AB, 1, 0, 32'h0, 0, o);
        n_checks++;
        if (o.sel !== 4'b1000 || o.addr !== 32'h100 || o.wdata !== 32'hABABABAB) begin
            n_fail++; $display("FAIL sb_bus got sel %b addr %h wdata %h want 1000 100 abababab",
                               o.sel, o.addr, o.wdata);
        end
        n_checks++;
        if (o.done_cycle != 3 || o.err !== 0) begin
            n_fail++; $display("FAIL sb_done got cycle %0d err %b want 3 0", o.done_cycle, o.err);
        end
    endtask

    task automatic test_loads();
        obs_t o;
        do_access(0, 3'b000, 32'h102, 32'h0, 0, 0, 32'h0080_0000, 0, o);
        n_checks++;
        if (o.rdata !== 32'hFFFFFF80 || o.err !== 0 || o.sel !== 4'b0100) begin
            n_fail++; $display("FAIL lb got rdata %h err %b sel %b want ffffff80 0 0100",
                               o.rdata, o.err, o.sel);
        end
        do_access(0, 3'b100, 32'h102, 32'h0, 0, 0, 32'h0080_0000, 0, o);
        n_checks++;
        if (o.rdata !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu got %h want 00000080", o.rdata);
        end
        do_access(0, 3'b001, 32'h102, 32'h0, 2, 0, 32'h8001_0000, 0, o);
        n_checks++;
        if (o.rdata !== 32'hFFFF8001 || o.sel !== 4'b1100 || o.done_cycle != 4) begin
            n_fail++; $display("FAIL lh got rdata %h sel %b cycle %0d want ffff8001 1100 4",
                               o.rdata, o.sel, o.done_cycle);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_access(0, 3'b101, 32'h101, 32'h0, 0, 0, 32'h1234_5678, 0, o);
        n_checks++;
        if (o.cyc_cycles != 0 || o.done_cycle != 1 || o.err !== 1 || o.rdata !== 0) begin
            n_fail++; $display("FAIL lhu_misaligned got cyc %0d cycle %0d err %b rdata %h want 0 1 1 0",
                               o.cyc_cycles, o.done_cycle, o.err, o.rdata);
        end
        do_access(0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h1234_5678, 0, o);
        n_checks++;
        if (o.cyc_cycles != 0 || o.done_cycle != 1 || o.err !== 1) begin
            n_fail++; $display("FAIL width_011 got cyc %0d cycle %0d err %b want 0 1 1",
                               o.cyc_cycles, o.done_cycle, o.err);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_access(0, 3'b010, 32'h200, 32'h0, -1, 0, 32'h5555_5555, 0, o);
        n_checks++;
        if (o.cyc_cycles != TIMEOUT || o.done_cycle != TIMEOUT + 1 || o.err !== 1 ||
            o.rdata !== 0 || o.unstable) begin
            n_fail++; $display("FAIL timeout got cyc %0d cycle %0d err %b rdata %h unstable %b want %0d %0d 1 0 0",
                               o.cyc_cycles, o.done_cycle, o.err, o.rdata, o.unstable,
                               TIMEOUT, TIMEOUT + 1);
        end
    endtask

    task automatic test_bus_error();
        obs_t o;
        do_access(0, 3'b010, 32'h300, 32'h0, 1, 1, 32'hCAFE_F00D, 0, o);
        n_checks++;
        if (o.err !== 1 || o.rdata !== 0 || o.done_cycle != 3) begin
            n_fail++; $display("FAIL bus_err got err %b rdata %h cycle %0d want 1 0 3",
                               o.err, o.rdata, o.done_cycle);
        end
        do_access(0, 3'b010, 32'h304, 32'h0, 0, 2, 32'hCAFE_F00D, 0, o);
        n_checks++;
        if (o.err !== 1 || o.rdata !== 0) begin
            n_fail++; $display("FAIL ack_and_err got err %b rdata %h want 1 0", o.err, o.rdata);
        end
    endtask

    task automatic test_valid_drop();
        obs_t o;
        do_access(0, 3'b010, 32'h400, 32'h0, 3, 0, 32'h0BAD_C0DE, 1, o);
        n_checks++;
        if (o.done_cycle != 5 || o.err !== 0 || o.rdata !== 32'h0BAD_C0DE || o.cyc_cycles != 4) begin
            n_fail++; $display("FAIL valid_drop got cycle %0d err %b rdata %h cyc %0d want 5 0 0badc0de 4",
                               o.done_cycle, o.err, o.rdata, o.cyc_cycles);
        end
    endtask

    task automatic test_reset_mid_access();
        int seen;
        bit saw_done;
        obs_t o;
        @(negedge clk);
        req_valid = 1; req_we = 1; req_width = 3'b010; req_addr = 32'h500; req_wdata = 32'h1357_9BDF;
        seen = 0;
        for (int c = 0; c < 10 && seen < 3; c++) begin
            @(negedge clk);
            if (bus_cyc) seen++;
        end
        n_checks++;
        if (seen != 3) begin
            n_fail++; $display("FAIL rst_mid_setup got %0d access cycles want 3", seen);
        end
        rst_n = 0;
        #1;
        n_checks++;
        if ({bus_cyc, bus_stb, bus_we, done, err} !== 5'b0 ||
            {bus_addr, bus_sel, bus_wdata, rdata} !== 100'h0) begin
            n_fail++; $display("FAIL rst_mid_outputs got ctrl %b addr %h sel %b wdata %h rdata %h want 0",
                               {bus_cyc, bus_stb, bus_we, done, err}, bus_addr, bus_sel, bus_wdata,
                               rdata);
        end
        req_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        bus_ack = 1;
        saw_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus_ack = 0;
            if (done || bus_cyc) saw_done = 1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++; $display("FAIL late_ack got activity 1 want 0");
        end
        do_access(0, 3'b001, 32'h502, 32'h0, 0, 0, 32'h7FFF_0000, 0, o);
        n_checks++;
        if (o.rdata !== 32'h00007FFF || o.err !== 0) begin
            n_fail++; $display("FAIL post_reset_lh got %h err %b want 00007fff 0", o.rdata, o.err);
        end
    endtask

    task automatic test_random();
        obs_t o;
        bit legal;
        logic [3:0] esel;
        logic [31:0] ewd, erd, a, d, srd, exp_rd;
        logic [2:0] w;
        logic we;
        int lat, mode, exp_cycle, exp_cyc;
        bit exp_err;
        for (int it = 0; it < 40; it++) begin
            w = 3'($urandom_range(0, 7));
            a = $urandom; d = $urandom; srd = $urandom; we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
            mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            model(w, a, d, srd, legal, esel, ewd, erd);
            exp_err   = !legal || lat < 0 || mode != 0;
            exp_rd    = (legal && !we && lat >= 0 && mode == 0) ? erd : 32'h0;
            exp_cycle = !legal ? 1 : (lat < 0 ? TIMEOUT + 1 : lat + 2);
            exp_cyc   = !legal ? 0 : (lat < 0 ? TIMEOUT : lat + 1);
            do_access(we, w, a, d, lat, mode, srd, 0, o);
            n_checks++;
            if (o.done_cycle != exp_cycle || o.cyc_cycles != exp_cyc || o.err !== exp_err ||
                o.rdata !== exp_rd) begin
                n_fail++; $display("FAIL rand%0d_result w %b a %h got cycle %0d cyc %0d err %b rdata %h want %0d %0d %b %h",
                                   it, w, a, o.done_cycle, o.cyc_cycles, o.err, o.rdata,
                                   exp_cycle, exp_cyc, exp_err, exp_rd);
            end
            if (legal) begin
                n_checks++;
                if (o.sel !== esel || o.addr !== {a[31:2], 2'b00} || o.wdata !== ewd ||
                    o.we !== we || o.unstable) begin
                    n_fail++; $display("FAIL rand%0d_bus got sel %b addr %h wdata %h we %b unstable %b want %b %h %h %b 0",
                                       it, o.sel, o.addr, o.wdata, o.we, o.unstable, esel,
                                       {a[31:2], 2'b00}, ewd, we);
                end
            end
            n_checks++;
            if (o.stall_bad || o.stall_at_done || o.done_after) begin
                n_fail++; $display("FAIL rand%0d_handshake got stall_bad %b stall_done %b done_after %b want 0 0 0",
                                   it, o.stall_bad, o.stall_at_done, o.done_after);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_loads();
        test_misaligned();
        test_timeout();
        test_bus_error();
        test_valid_drop();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
